// File: rtl/chip8_pkg.sv
// Shared types and constants for the CHIP-8 register-to-register instruction sequencer.
// Also holds the opcode decoder that maps an instruction word to its register access path.
package chip8_pkg;

  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned OPCODE_W  = 16;

  localparam logic [ADDR_W-1:0] FLAG_REG   = 4'hF;
  localparam logic [3:0]        OP_LD_IMM  = 4'h6;
  localparam logic [3:0]        OP_ADD_IMM = 4'h7;
  localparam logic [3:0]        OP_ALU     = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ_X,
    ST_READ_Y,
    ST_WRITE_X,
    ST_WRITE_F
  } seq_state_e;

  // Values 0-7 and E match the 8XYN subfunction nibble; ADD_NF is the flagless 7XNN add.
  typedef enum logic [3:0] {
    ALU_MOV    = 4'h0,
    ALU_OR     = 4'h1,
    ALU_AND    = 4'h2,
    ALU_XOR    = 4'h3,
    ALU_ADD    = 4'h4,
    ALU_SUB    = 4'h5,
    ALU_SHR    = 4'h6,
    ALU_SUBN   = 4'h7,
    ALU_ADD_NF = 4'h8,
    ALU_SHL    = 4'hE
  } alu_fn_e;

  typedef struct packed {
    logic              valid;
    logic              rd_x;
    logic              rd_y;
    logic              use_imm;
    alu_fn_e           fn;
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    logic [DATA_W-1:0] nn;
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [OPCODE_W-1:0] op);
    op_dec_t d;
    d.valid   = 1'b0;
    d.rd_x    = 1'b0;
    d.rd_y    = 1'b0;
    d.use_imm = 1'b0;
    d.fn      = ALU_MOV;
    d.x       = op[11:8];
    d.y       = op[7:4];
    d.nn      = op[7:0];
    case (op[15:12])
      OP_LD_IMM: begin
        d.valid   = 1'b1;
        d.use_imm = 1'b1;
      end
      OP_ADD_IMM: begin
        d.valid   = 1'b1;
        d.rd_x    = 1'b1;
        d.use_imm = 1'b1;
        d.fn      = ALU_ADD_NF;
      end
      OP_ALU: begin
        case (op[3:0])
          4'h0: begin
            d.valid = 1'b1;
            d.rd_y  = 1'b1;
          end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7: begin
            d.valid = 1'b1;
            d.rd_x  = 1'b1;
            d.rd_y  = 1'b1;
            d.fn    = alu_fn_e'(op[3:0]);
          end
          4'h6, 4'hE: begin
            d.valid = 1'b1;
            d.rd_x  = 1'b1;
            d.fn    = alu_fn_e'(op[3:0]);
          end
          default: d.valid = 1'b0;
        endcase
      end
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Control-unit handshake plus register-file port of the ALU op sequencer.
interface alu_op_sequencer_if;
  logic                                start;
  logic [chip8_pkg::OPCODE_W-1:0]      opcode;
  logic                                busy;
  logic                                done;
  logic                                illegal;
  logic [chip8_pkg::ADDR_W-1:0]        reg_address;
  logic                                reg_write;
  logic [chip8_pkg::DATA_W-1:0]        reg_write_data;
  logic [chip8_pkg::DATA_W-1:0]        reg_data;

  modport slave (
    input  start, opcode, reg_data,
    output busy, done, illegal, reg_address, reg_write, reg_write_data
  );

  modport master (
    output start, opcode, reg_data,
    input  busy, done, illegal, reg_address, reg_write, reg_write_data
  );
endinterface

// File: rtl/alu_op_sequencer_alu8.sv
// Combinational 8-bit ALU for the CHIP-8 8XYN family plus the flagless 7XNN add.
module alu8
  import chip8_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_fn_e           i_subfn,
  output logic [DATA_W-1:0] o_result,
  output logic              o_flag,
  output logic              o_writes_flag
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff_ab;
  logic [DATA_W:0] w_diff_ba;

  // Ninth bit of a difference is the borrow, so no borrow means minuend >= subtrahend.
  assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff_ab = {1'b0, i_a} - {1'b0, i_b};
  assign w_diff_ba = {1'b0, i_b} - {1'b0, i_a};

  always_comb begin
    o_result      = '0;
    o_flag        = 1'b0;
    o_writes_flag = 1'b0;
    case (i_subfn)
      ALU_MOV:    o_result = i_b;
      ALU_OR:     o_result = i_a | i_b;
      ALU_AND:    o_result = i_a & i_b;
      ALU_XOR:    o_result = i_a ^ i_b;
      ALU_ADD_NF: o_result = w_sum[DATA_W-1:0];
      ALU_ADD: begin
        o_result      = w_sum[DATA_W-1:0];
        o_flag        = w_sum[DATA_W];
        o_writes_flag = 1'b1;
      end
      ALU_SUB: begin
        o_result      = w_diff_ab[DATA_W-1:0];
        o_flag        = ~w_diff_ab[DATA_W];
        o_writes_flag = 1'b1;
      end
      ALU_SUBN: begin
        o_result      = w_diff_ba[DATA_W-1:0];
        o_flag        = ~w_diff_ba[DATA_W];
        o_writes_flag = 1'b1;
      end
      ALU_SHR: begin
        o_result      = {1'b0, i_a[DATA_W-1:1]};
        o_flag        = i_a[0];
        o_writes_flag = 1'b1;
      end
      ALU_SHL: begin
        o_result      = {i_a[DATA_W-2:0], 1'b0};
        o_flag        = i_a[DATA_W-1];
        o_writes_flag = 1'b1;
      end
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle executor for CHIP-8 6XNN, 7XNN and 8XYN instructions; sole master of the
// 16x8 register file while busy. All register-file outputs are registered from state + latches.
module alu_op_sequencer
  import chip8_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  alu_op_sequencer_if.slave  bus
);

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_x;
  logic [ADDR_W-1:0] r_y;
  logic [DATA_W-1:0] r_nn;
  alu_fn_e           r_fn;
  logic              r_rd_y;
  logic              r_use_imm;
  logic [DATA_W-1:0] r_vx;
  logic [DATA_W-1:0] r_vy;

  logic              r_busy;
  logic              r_done;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_reg_address;
  logic              r_reg_write;
  logic [DATA_W-1:0] r_reg_write_data;

  op_dec_t           w_dec;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_result;
  logic              w_flag;
  logic              w_writes_flag;

  assign w_dec = decode_op(bus.opcode);

  // Operand being captured this cycle feeds the ALU directly so WRITE_X data is ready on entry.
  assign w_a = (r_state == ST_READ_X) ? bus.reg_data : r_vx;
  assign w_b = r_use_imm ? r_nn : ((r_state == ST_READ_Y) ? bus.reg_data : r_vy);

  alu8 u_alu (
    .i_a           (w_a),
    .i_b           (w_b),
    .i_subfn       (r_fn),
    .o_result      (w_result),
    .o_flag        (w_flag),
    .o_writes_flag (w_writes_flag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_x              <= '0;
      r_y              <= '0;
      r_nn             <= '0;
      r_fn             <= ALU_MOV;
      r_rd_y           <= 1'b0;
      r_use_imm        <= 1'b0;
      r_vx             <= '0;
      r_vy             <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_illegal        <= 1'b0;
      r_reg_address    <= '0;
      r_reg_write      <= 1'b0;
      r_reg_write_data <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_reg_address    <= '0;
          r_reg_write      <= 1'b0;
          r_reg_write_data <= '0;
          r_busy           <= 1'b0;
          if (bus.start) begin
            r_x       <= w_dec.x;
            r_y       <= w_dec.y;
            r_nn      <= w_dec.nn;
            r_fn      <= w_dec.fn;
            r_rd_y    <= w_dec.rd_y;
            r_use_imm <= w_dec.use_imm;
            if (!w_dec.valid) begin
              r_done    <= 1'b1;
              r_illegal <= 1'b1;
            end else if (w_dec.rd_x) begin
              r_state       <= ST_READ_X;
              r_busy        <= 1'b1;
              r_reg_address <= w_dec.x;
            end else if (w_dec.rd_y) begin
              r_state       <= ST_READ_Y;
              r_busy        <= 1'b1;
              r_reg_address <= w_dec.y;
            end else begin
              // 6XNN: immediate goes straight to the write state.
              r_state          <= ST_WRITE_X;
              r_busy           <= 1'b1;
              r_reg_address    <= w_dec.x;
              r_reg_write      <= 1'b1;
              r_reg_write_data <= w_dec.nn;
            end
          end
        end
        ST_READ_X: begin
          r_vx <= bus.reg_data;
          if (r_rd_y) begin
            r_state       <= ST_READ_Y;
            r_reg_address <= r_y;
          end else begin
            r_state          <= ST_WRITE_X;
            r_reg_address    <= r_x;
            r_reg_write      <= 1'b1;
            r_reg_write_data <= w_result;
          end
        end
        ST_READ_Y: begin
          r_vy             <= bus.reg_data;
          r_state          <= ST_WRITE_X;
          r_reg_address    <= r_x;
          r_reg_write      <= 1'b1;
          r_reg_write_data <= w_result;
        end
        ST_WRITE_X: begin
          if (w_writes_flag) begin
            r_state          <= ST_WRITE_F;
            r_reg_address    <= FLAG_REG;
            r_reg_write      <= 1'b1;
            r_reg_write_data <= DATA_W'(w_flag);
          end else begin
            r_state          <= ST_IDLE;
            r_busy           <= 1'b0;
            r_done           <= 1'b1;
            r_reg_address    <= '0;
            r_reg_write      <= 1'b0;
            r_reg_write_data <= '0;
          end
        end
        ST_WRITE_F: begin
          r_state          <= ST_IDLE;
          r_busy           <= 1'b0;
          r_done           <= 1'b1;
          r_reg_address    <= '0;
          r_reg_write      <= 1'b0;
          r_reg_write_data <= '0;
        end
        default: begin
          r_state          <= ST_IDLE;
          r_busy           <= 1'b0;
          r_reg_address    <= '0;
          r_reg_write      <= 1'b0;
          r_reg_write_data <= '0;
        end
      endcase
    end
  end

  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.illegal        = r_illegal;
  assign bus.reg_address    = r_reg_address;
  assign bus.reg_write      = r_reg_write;
  assign bus.reg_write_data = r_reg_write_data;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural register file plus an instruction-level model
// predicting each cycle's register access, done/illegal timing and the final register contents.
module tb_alu_op_sequencer;
  import chip8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rf [16] = '{default: 8'h00};
  assign bus.reg_data = rf[bus.reg_address];
  always @(posedge clk) if (bus.reg_write) rf[bus.reg_address] <= bus.reg_write_data;

  int vectors     = 0;
  int miscompares = 0;

  int m_rf [16];
  int e_addr [4];
  int e_wr [4];
  int e_data [4];
  int e_n;
  bit e_legal;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    vectors++;
    assert (obs === 32'(exp)) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int a, input int w, input int d);
    e_addr[e_n] = a;
    e_wr[e_n]   = w;
    e_data[e_n] = d;
    e_n++;
  endtask

  // Instruction-level reference: register access list per CHIP-8 semantics, then apply writes.
  task automatic model(input logic [15:0] op);
    int x, y, nn, n, vx, vy, s;
    x  = int'(op[11:8]);
    y  = int'(op[7:4]);
    nn = int'(op[7:0]);
    n  = int'(op[3:0]);
    vx = m_rf[x];
    vy = m_rf[y];
    e_n = 0;
    e_legal = 1'b1;
    case (op[15:12])
      4'h6: step(x, 1, nn);
      4'h7: begin step(x, 0, 0); step(x, 1, (vx + nn) % 256); end
      4'h8: begin
        case (n)
          0: begin step(y, 0, 0); step(x, 1, vy); end
          1: begin step(x, 0, 0); step(y, 0, 0); step(x, 1, vx | vy); end
          2: begin step(x, 0, 0); step(y, 0, 0); step(x, 1, vx & vy); end
          3: begin step(x, 0, 0); step(y, 0, 0); step(x, 1, vx ^ vy); end
          4: begin
            s = vx + vy;
            step(x, 0, 0); step(y, 0, 0); step(x, 1, s % 256); step(15, 1, s / 256);
          end
          5: begin
            step(x, 0, 0); step(y, 0, 0);
            step(x, 1, (vx - vy + 256) % 256); step(15, 1, (vx >= vy) ? 1 : 0);
          end
          7: begin
            step(x, 0, 0); step(y, 0, 0);
            step(x, 1, (vy - vx + 256) % 256); step(15, 1, (vy >= vx) ? 1 : 0);
          end
          6:  begin step(x, 0, 0); step(x, 1, vx / 2); step(15, 1, vx % 2); end
          14: begin step(x, 0, 0); step(x, 1, (vx * 2) % 256); step(15, 1, vx / 128); end
          default: e_legal = 1'b0;
        endcase
      end
      default: e_legal = 1'b0;
    endcase
    for (int k = 0; k < e_n; k++) if (e_wr[k] != 0) m_rf[e_addr[k]] = e_data[k];
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic run_op(input logic [15:0] op, input bit poke_busy);
    model(op);
    bus.start  = 1'b1;
    bus.opcode = op;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.opcode = 16'($urandom);
    for (int k = 0; k < e_n; k++) begin
      chk($sformatf("busy[%0h.%0d]", op, k), 32'(bus.busy), 1);
      chk($sformatf("done_early[%0h.%0d]", op, k), 32'(bus.done), 0);
      chk($sformatf("addr[%0h.%0d]", op, k), 32'(bus.reg_address), e_addr[k]);
      chk($sformatf("wr[%0h.%0d]", op, k), 32'(bus.reg_write), e_wr[k]);
      if (e_wr[k] != 0) chk($sformatf("wdata[%0h.%0d]", op, k), 32'(bus.reg_write_data), e_data[k]);
      if (poke_busy && k == 0 && e_n >= 2) begin
        bus.start  = 1'b1;
        bus.opcode = 16'h6F00;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    chk($sformatf("done[%0h]", op), 32'(bus.done), 1);
    chk($sformatf("busy_end[%0h]", op), 32'(bus.busy), 0);
    chk($sformatf("illegal[%0h]", op), 32'(bus.illegal), e_legal ? 0 : 1);
    chk($sformatf("wr_idle[%0h]", op), 32'(bus.reg_write), 0);
    chk($sformatf("addr_idle[%0h]", op), 32'(bus.reg_address), 0);
    chk($sformatf("wdata_idle[%0h]", op), 32'(bus.reg_write_data), 0);
    @(posedge clk); #1;
    chk($sformatf("done_once[%0h]", op), 32'(bus.done), 0);
    chk($sformatf("illegal_once[%0h]", op), 32'(bus.illegal), 0);
    chk($sformatf("busy_after[%0h]", op), 32'(bus.busy), 0);
    for (int i = 0; i < 16; i++) chk($sformatf("rf%0d[%0h]", i, op), 32'(rf[i]), m_rf[i]);
  endtask

  task automatic load(input int r, input int v);
    run_op({4'h6, 4'(r), 8'(v)}, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_illegal"}, 32'(bus.illegal), 0);
    chk({tag, "_addr"}, 32'(bus.reg_address), 0);
    chk({tag, "_wr"}, 32'(bus.reg_write), 0);
    chk({tag, "_wdata"}, 32'(bus.reg_write_data), 0);
  endtask

  initial begin
    logic [15:0] op;
    logic [3:0]  n_legal [9];
    n_legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
    for (int i = 0; i < 16; i++) m_rf[i] = 0;
    bus.start  = 1'b0;
    bus.opcode = 16'h0000;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");

    // Directed cases.
    load(3, 8'h10);
    run_op(16'h7305, 1'b0);
    load(1, 8'hF0); load(2, 8'h20);
    run_op(16'h8124, 1'b0);
    load(1, 8'h05); load(2, 8'h07);
    run_op(16'h8125, 1'b0);
    load(1, 8'h05);
    run_op(16'h8127, 1'b0);
    load(15, 8'h81);
    run_op(16'h8F0E, 1'b0);
    run_op(16'h9120, 1'b0);
    run_op(16'h8128, 1'b0);
    load(2, 8'h3C); load(3, 8'hA5);
    run_op(16'h8234, 1'b1);
    run_op(16'h8236, 1'b1);

    // Reset during WRITE_X of 8124: no VX or VF write must land.
    load(1, 8'hF0); load(2, 8'h20); load(15, 8'h55);
    bus.start  = 1'b1;
    bus.opcode = 16'h8124;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_wr_pre", 32'(bus.reg_write), 1);
    chk("abort_wdata_pre", 32'(bus.reg_write_data), 8'h10);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("abort_idle");
    chk("abort_v1", 32'(rf[1]), 8'hF0);
    chk("abort_vf", 32'(rf[15]), 8'h55);

    // Randomized register contents and instruction mix.
    for (int i = 0; i < 16; i++) load(i, int'($urandom_range(0, 255)));
    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        0, 1: op = {4'h6, 12'($urandom)};
        2, 3: op = {4'h7, 12'($urandom)};
        9: begin
          if ($urandom_range(0, 1) == 0)
            op = {4'($urandom_range(0, 5)), 12'($urandom)};
          else if ($urandom_range(0, 1) == 0)
            op = {4'($urandom_range(9, 15)), 12'($urandom)};
          else
            op = {4'h8, 8'($urandom), 4'($urandom_range(8, 13))};
        end
        default: op = {4'h8, 8'($urandom), n_legal[$urandom_range(0, 8)]};
      endcase
      run_op(op, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
